// File: rtl/plot_pkg.sv
// Shared types and frame constants for the plotter raster feeder.
package plot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } plot_state_t;

  localparam int PLOT_W = 80;
  localparam int PLOT_H = 106;
  localparam int POS_W  = 7;

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/plot_raster_feeder_if.sv
// Pixel presentation handshake between the raster feeder and plotter_control.
interface plot_raster_feeder_if;
  import plot_pkg::*;

  logic             pixel_valid_out;
  logic             pixel_ready_in;
  logic             pixel_value_out;
  logic [POS_W-1:0] row_out;
  logic [POS_W-1:0] col_out;

  modport master (
    output pixel_valid_out,
    output pixel_value_out,
    output row_out,
    output col_out,
    input  pixel_ready_in
  );

  modport slave (
    input  pixel_valid_out,
    input  pixel_value_out,
    input  row_out,
    input  col_out,
    output pixel_ready_in
  );

endinterface

// File: rtl/serpentine_counter.sv
// Frame walker: row/col position, running row base address and scan direction.
module serpentine_counter
  import plot_pkg::*;
#(
  parameter int WIDTH      = PLOT_W,
  parameter int HEIGHT     = PLOT_H,
  parameter int ADDR_W     = addr_w(PLOT_W, PLOT_H),
  parameter int SERPENTINE = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear,
  input  logic              advance,
  output logic [POS_W-1:0]  row,
  output logic [POS_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel
);

  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q;
  logic              dir_q, dir_d;
  logic              row_end;

  // dir_q = 1 means the current row is scanned right-to-left
  assign row_end = dir_q ? (col_q == '0) : (col_q == POS_W'(WIDTH - 1));

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    base_d = base_q;
    dir_d  = dir_q;
    if (row_end) begin
      row_d  = row_q + 1'b1;
      base_d = base_q + ADDR_W'(WIDTH);
      if (SERPENTINE != 0) begin
        dir_d = ~dir_q;
      end else begin
        col_d = '0;
      end
    end else if (dir_q) begin
      col_d = col_q - 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else if (advance) begin
      row_q  <= row_d;
      col_q  <= col_d;
      base_q <= base_d;
      dir_q  <= dir_d;
      addr_q <= base_d + ADDR_W'(col_d);
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign addr       = addr_q;
  assign last_pixel = (row_q == POS_W'(HEIGHT - 1)) && row_end;

endmodule

// File: rtl/plot_raster_feeder.sv
// Freezes the b/w frame and feeds it pixel by pixel to plotter_control.
//   state   | meaning
//   IDLE    | waiting for start_in
//   FETCH   | address on BRAM, waiting out the read latency
//   PRESENT | pixel offered to the plotter until ready
//   DONE    | one-cycle done pulse, then back to IDLE
module plot_raster_feeder
  import plot_pkg::*;
#(
  parameter int WIDTH        = PLOT_W,
  parameter int HEIGHT       = PLOT_H,
  parameter int ADDR_W       = addr_w(PLOT_W, PLOT_H),
  parameter int READ_LATENCY = 2,
  parameter int SERPENTINE   = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  output logic [ADDR_W-1:0]    bram_addr_out,
  input  logic                 bram_data_in,
  output logic                 busy_out,
  output logic                 done_out,
  plot_raster_feeder_if.master pix
);

  plot_state_t      state_q, state_d;
  logic [2:0]       lat_q;
  logic             value_q;
  logic             clear, advance, capture;
  logic             last_pixel;
  logic [POS_W-1:0] row, col;

  serpentine_counter #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_W     (ADDR_W),
    .SERPENTINE (SERPENTINE)
  ) u_counter (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear      (clear),
    .advance    (advance),
    .row        (row),
    .col        (col),
    .addr       (bram_addr_out),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          clear   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort_in) begin
          state_d = IDLE;
        end else if (lat_q == 3'(READ_LATENCY)) begin
          capture = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // abort wins over a handshake in the same cycle
        if (abort_in) begin
          state_d = IDLE;
        end else if (pix.pixel_ready_in) begin
          if (last_pixel) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      lat_q   <= '0;
      value_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= (state_q == FETCH && state_d == FETCH) ? lat_q + 3'd1 : 3'd0;
      if (capture) begin
        value_q <= bram_data_in;
      end
    end
  end

  assign pix.pixel_valid_out = (state_q == PRESENT);
  assign pix.pixel_value_out = value_q;
  assign pix.row_out         = row;
  assign pix.col_out         = col;
  assign busy_out            = (state_q == FETCH) || (state_q == PRESENT);
  assign done_out            = (state_q == DONE);

endmodule

// File: tb/tb_plot_raster_feeder.sv
// Directed bench for plot_raster_feeder with a 2-cycle BRAM model (addr%3==0 -> 1).
module tb_plot_raster_feeder;
  import plot_pkg::*;

  localparam int W  = 80;
  localparam int H  = 106;
  localparam int AW = 14;
  localparam int RL = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          abort_in;
  logic [AW-1:0] bram_addr_out;
  logic          bram_data_in;
  logic          busy_out;
  logic          done_out;

  plot_raster_feeder_if pix ();

  plot_raster_feeder #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .ADDR_W       (AW),
    .READ_LATENCY (RL),
    .SERPENTINE   (1)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .abort_in      (abort_in),
    .bram_addr_out (bram_addr_out),
    .bram_data_in  (bram_data_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .pix           (pix.master)
  );

  always #5 clk_in = ~clk_in;

  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk_in) begin
    d1 <= ((int'(bram_addr_out) % 3) == 0);
    d2 <= d1;
  end
  assign bram_data_in = d2;

  int cyc = 0, hs_cnt = 0, done_cnt = 0;
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (pix.pixel_valid_out && pix.pixel_ready_in) hs_cnt <= hs_cnt + 1;
    if (done_out) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pos_word(input int r, input int c);
    logic v;
    v = (((r * W + c) % 3) == 0);
    return {35'd0, 7'(r), 7'(c), 14'(r * W + c), v};
  endfunction

  function automatic logic [63:0] dut_word();
    return {35'd0, pix.row_out, pix.col_out, bram_addr_out, pix.pixel_value_out};
  endfunction

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (pix.pixel_valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  initial begin
    bit ok;
    bit idle_bad;
    bit stall_bad;
    int r, c, prev_cyc, hs0, d0, idx;

    rst_in = 1'b1;
    start_in = 1'b0;
    abort_in = 1'b0;
    pix.pixel_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_outputs", {busy_out, done_out, pix.pixel_valid_out, pix.pixel_value_out,
                            pix.row_out, pix.col_out, bram_addr_out}, 64'd0);
    rst_in = 1'b0;
    idle_bad = 1'b0;
    d0 = done_cnt;
    repeat (10) begin
      @(negedge clk_in);
      if (busy_out !== 1'b0 || done_out !== 1'b0 || pix.pixel_valid_out !== 1'b0 ||
          bram_addr_out !== '0 || pix.row_out !== '0 || pix.col_out !== '0) idle_bad = 1'b1;
    end
    check("idle_outputs_zero", idle_bad, 1'b0);
    check("idle_abort_ignored_busy", busy_out, 1'b0);
    abort_in = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b0;
    check("idle_abort_busy", busy_out, 1'b0);

    // full frame with ready tied high
    hs0 = hs_cnt;
    d0 = done_cnt;
    pix.pixel_ready_in = 1'b1;
    pulse_start();
    check("start_busy", busy_out, 1'b1);
    r = 0; c = 0; prev_cyc = 0;
    for (int k = 0; k < W * H; k++) begin
      wait_valid(12, ok);
      if (!ok) begin
        check("frame_timeout", ok, 1'b1);
        break;
      end
      check("frame_pix", dut_word(), pos_word(r, c));
      if (k > 0) check("frame_spacing", 64'(cyc - prev_cyc), 64'd4);
      prev_cyc = cyc;
      if (k == 0) check("first_value", pix.pixel_value_out, 1'b1);
      if (k >= 1 && k <= 3) check("first_row_col", {pix.row_out, pix.col_out}, {7'd0, 7'(k)});
      if (k == 80) check("row1_start", {pix.row_out, pix.col_out, bram_addr_out}, {7'd1, 7'd79, 14'd159});
      if (k == W * H - 1) check("last_pixel", {pix.row_out, pix.col_out, bram_addr_out}, {7'd105, 7'd0, 14'd8400});
      if (r % 2 == 0) begin
        if (c == W - 1) r++; else c++;
      end else begin
        if (c == 0) r++; else c--;
      end
    end
    @(negedge clk_in);
    check("done_pulse", {done_out, busy_out, pix.pixel_valid_out}, {1'b1, 1'b0, 1'b0});
    @(negedge clk_in);
    check("done_one_cycle", done_out, 1'b0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("handshake_count", 64'(hs_cnt - hs0), 64'd8480);
    check("idle_after_done", busy_out, 1'b0);

    // stall at (3,10)
    pulse_start();
    idx = -1;
    for (int k = 0; k < 400; k++) begin
      wait_valid(12, ok);
      if (!ok) break;
      if (pix.row_out == 7'd3 && pix.col_out == 7'd10) begin
        pix.pixel_ready_in = 1'b0;
        idx = k;
        break;
      end
    end
    check("stall_index", 64'(idx), 64'd309);
    check("stall_pix", dut_word(), pos_word(3, 10));
    stall_bad = 1'b0;
    repeat (50) begin
      @(negedge clk_in);
      if (pix.pixel_valid_out !== 1'b1 || dut_word() !== pos_word(3, 10)) stall_bad = 1'b1;
    end
    check("stall_stable", stall_bad, 1'b0);
    pix.pixel_ready_in = 1'b1;
    wait_valid(12, ok);
    check("stall_release_ok", ok, 1'b1);
    check("after_stall_pix", dut_word(), pos_word(3, 9));

    // abort at (20,5) together with ready
    d0 = done_cnt;
    idx = -1;
    for (int k = 0; k < 2000; k++) begin
      wait_valid(12, ok);
      if (!ok) break;
      if (pix.row_out == 7'd20 && pix.col_out == 7'd5) begin
        abort_in = 1'b1;
        idx = k;
        break;
      end
    end
    check("abort_reached", 64'(idx), 64'd1294);
    @(negedge clk_in);
    abort_in = 1'b0;
    check("abort_idle", {pix.pixel_valid_out, busy_out, done_out}, 3'b000);
    repeat (5) @(negedge clk_in);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_stays_idle", busy_out, 1'b0);

    pulse_start();
    wait_valid(12, ok);
    pix.pixel_ready_in = 1'b0;
    check("restart_ok", ok, 1'b1);
    check("restart_pix", dut_word(), pos_word(0, 0));

    // start while busy is ignored, then reset mid-PRESENT
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("busy_start_ignored", {pix.pixel_valid_out, busy_out, dut_word()}, {1'b1, 1'b1, pos_word(0, 0)});
    d0 = done_cnt;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midjob_reset", {busy_out, done_out, pix.pixel_valid_out, pix.pixel_value_out,
                           pix.row_out, pix.col_out, bram_addr_out}, 64'd0);
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check("reset_no_done", 64'(done_cnt - d0), 64'd0);
    check("reset_idle", busy_out, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
